// File: rtl/axis_delay_calibrator.sv
// ---------------------------------------------------------------------------
// axis_delay_calibrator
//
// Purpose: measures the loop latency of an external AXI-Stream path by
// emitting a probe beat and timing how long its echo takes to return. It then
// programs the adjustable delay line so a companion stream lines up with the
// echoed stream. Intended to run once at bring-up or on a re-cal request.
//
// Configuration macro: AXIS_DELAY_CAL_MULTI_EN
//   undefined : one probe, one measurement (NUM_TRIALS is unused)
//   defined   : NUM_TRIALS probes back to back; every trial must measure the
//               same latency as the first, otherwise calibration fails
//
// Ports:
//   clk_i              clock
//   rst_i              synchronous, active-high reset
//   start_i            1-cycle pulse, starts calibration from IDLE/LOCKED/ERROR
//   delay_offset_i     unsigned offset added to the measured latency
//   m_axis_tdata_o     probe beat data
//   m_axis_tvalid_o    probe valid (sink always accepts, no tready)
//   m_axis_tlast_o     asserted with every probe beat
//   s_axis_tdata_i     echo stream data
//   s_axis_tvalid_i    echo stream valid
//   delay_count_o      delay line setting, changes only when locking
//   measured_latency_o most recent measured loop latency
//   busy_o             calibration in progress (PROBE/WAIT/CHECK)
//   locked_o           calibration succeeded
//   error_o            calibration failed (lost echo, illegal delay, jitter)
// ---------------------------------------------------------------------------
module axis_delay_calibrator #(
  parameter int                    DATA_WIDTH     = 256,
  parameter int                    MAX_LATENCY    = 50,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] PROBE_PATTERN  = {(DATA_WIDTH/32){32'hA5C3_5A3C}},
  parameter int                    NUM_TRIALS     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [15:0]           delay_offset_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  output logic                  m_axis_tlast_o,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic                  s_axis_tvalid_i,
  output logic [15:0]           delay_count_o,
  output logic [15:0]           measured_latency_o,
  output logic                  busy_o,
  output logic                  locked_o,
  output logic                  error_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_WAIT,
    S_CHECK,
    S_LOCKED,
    S_ERROR
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [DATA_WIDTH-1:0]   tdata_q;
  logic                    tvalid_q;
  logic                    tlast_q;
  logic [15:0]             delay_q;
  logic [15:0]             meas_q;
  logic                    busy_q;
  logic                    locked_q;
  logic                    error_q;

  logic                    match_d;
  logic                    timeout_d;
  logic [15:0]             check_lat_d;
  logic [16:0]             sum_d;
  logic                    sum_ok_d;

`ifdef AXIS_DELAY_CAL_MULTI_EN
  localparam int TW = (NUM_TRIALS > 1) ? $clog2(NUM_TRIALS) : 1;

  logic [TW-1:0] trial_q;
  logic [15:0]   ref_q;
  logic          last_trial_d;
  logic          ref_mismatch_d;

  // Trial 0 defines the reference latency; later trials only compare against it.
  always_comb begin
    last_trial_d   = (trial_q == TW'(NUM_TRIALS - 1));
    ref_mismatch_d = (trial_q != '0) && (16'(cnt_q) != ref_q);
  end
`else
  // Single-probe build has no use for the trial count.
  logic unused_num_trials;
  assign unused_num_trials = ^NUM_TRIALS;
`endif

  // Echo match, timeout and the 17-bit sum are shared by the FSM below.
  // Timeout fires when the count is about to reach TIMEOUT_CYCLES, so error
  // shows up exactly TIMEOUT_CYCLES cycles after the probe beat; a match in
  // that same last cycle still takes priority.
  always_comb begin
    match_d   = s_axis_tvalid_i && (s_axis_tdata_i == PROBE_PATTERN);
    timeout_d = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`ifdef AXIS_DELAY_CAL_MULTI_EN
    check_lat_d = ref_q;
`else
    check_lat_d = meas_q;
`endif
    sum_d    = {1'b0, check_lat_d} + {1'b0, delay_offset_i};
    sum_ok_d = (sum_d != 17'd0) && (sum_d <= 17'(MAX_LATENCY));
  end

  // Calibration FSM. Every output is a register updated alongside the state,
  // so each flag changes on the same edge as the state it reflects.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      delay_q  <= 16'd1;
      meas_q   <= 16'd0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
`ifdef AXIS_DELAY_CAL_MULTI_EN
      trial_q  <= '0;
      ref_q    <= 16'd0;
`endif
    end else begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_LOCKED, S_ERROR: begin
          if (start_i) begin
            state_q  <= S_PROBE;
            tdata_q  <= PROBE_PATTERN;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b1;
            busy_q   <= 1'b1;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
`ifdef AXIS_DELAY_CAL_MULTI_EN
            trial_q  <= '0;
`endif
          end
        end
        S_PROBE: begin
          cnt_q   <= CW'(1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (match_d) begin
            meas_q <= 16'(cnt_q);
`ifdef AXIS_DELAY_CAL_MULTI_EN
            if (trial_q == '0) begin
              ref_q <= 16'(cnt_q);
            end
            if (ref_mismatch_d) begin
              state_q <= S_ERROR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else if (last_trial_d) begin
              state_q <= S_CHECK;
            end else begin
              trial_q  <= trial_q + TW'(1);
              state_q  <= S_PROBE;
              tdata_q  <= PROBE_PATTERN;
              tvalid_q <= 1'b1;
              tlast_q  <= 1'b1;
            end
`else
            state_q <= S_CHECK;
`endif
          end else if (timeout_d) begin
            state_q <= S_ERROR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_CHECK: begin
          busy_q <= 1'b0;
          if (sum_ok_d) begin
            delay_q  <= sum_d[15:0];
            state_q  <= S_LOCKED;
            locked_q <= 1'b1;
          end else begin
            state_q <= S_ERROR;
            error_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata_o     = tdata_q;
  assign m_axis_tvalid_o    = tvalid_q;
  assign m_axis_tlast_o     = tlast_q;
  assign delay_count_o      = delay_q;
  assign measured_latency_o = meas_q;
  assign busy_o             = busy_q;
  assign locked_o           = locked_q;
  assign error_o            = error_q;

endmodule

// File: tb/tb_axis_delay_calibrator.sv
// ---------------------------------------------------------------------------
// tb_axis_delay_calibrator
//
// Purpose: drives axis_delay_calibrator through a loopback model of the
// external path (configurable per-probe delay, optional junk beats) and
// compares every output on every cycle against an expected timeline built
// from the calibration rules, plus a few hand-computed spot values.
// Honours AXIS_DELAY_CAL_MULTI_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_axis_delay_calibrator;

  localparam int DATA_WIDTH     = 256;
  localparam int MAX_LATENCY    = 50;
  localparam int TIMEOUT_CYCLES = 1024;
  localparam int NUM_TRIALS     = 4;
  localparam int WIN            = 1200;
  localparam logic [DATA_WIDTH-1:0] PATTERN = {(DATA_WIDTH/32){32'hA5C3_5A3C}};
`ifdef AXIS_DELAY_CAL_MULTI_EN
  localparam int TRIALS = NUM_TRIALS;
`else
  localparam int TRIALS = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [15:0]           delayOffset = 16'd0;
  logic [DATA_WIDTH-1:0] mTdata;
  logic                  mTvalid;
  logic                  mTlast;
  logic [DATA_WIDTH-1:0] sTdata = '0;
  logic                  sTvalid = 1'b0;
  logic [15:0]           delayCount;
  logic [15:0]           measuredLatency;
  logic                  busy;
  logic                  locked;
  logic                  error;

  axis_delay_calibrator #(
    .DATA_WIDTH     (DATA_WIDTH),
    .MAX_LATENCY    (MAX_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .PROBE_PATTERN  (PATTERN),
    .NUM_TRIALS     (NUM_TRIALS)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .start_i            (start),
    .delay_offset_i     (delayOffset),
    .m_axis_tdata_o     (mTdata),
    .m_axis_tvalid_o    (mTvalid),
    .m_axis_tlast_o     (mTlast),
    .s_axis_tdata_i     (sTdata),
    .s_axis_tvalid_i    (sTvalid),
    .delay_count_o      (delayCount),
    .measured_latency_o (measuredLatency),
    .busy_o             (busy),
    .locked_o           (locked),
    .error_o            (error)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  int errCount = 0;
  int checkCount = 0;

  // Expected per-cycle outputs, indexed by cycles since the start pulse.
  logic        expValid  [WIN];
  logic        expBusy   [WIN];
  logic        expLocked [WIN];
  logic        expError  [WIN];
  logic [15:0] expDelay  [WIN];
  logic [15:0] expMeas   [WIN];
  int          tlLen = 1;
  int          baseCycle = 0;
  bit          checkEn = 1'b0;

  // Values the outputs settle to at the end of the previous scenario.
  logic        modelLocked = 1'b0;
  logic        modelError  = 1'b0;
  logic [15:0] modelDelay  = 16'd1;
  logic [15:0] modelMeas   = 16'd0;

  // Loopback path state.
  int trialDelay [8];
  int echoQ [$];
  bit echoOn = 1'b0;
  bit junkOn = 1'b0;
  int probeIdx = 0;
  int probeCount = 0;
  int firstProbeCycle = -1;
  int lastEchoCycle = -1;
  int lockSeen = -1;
  int errSeen = -1;

  task automatic checkOutput(input string name, input logic [DATA_WIDTH-1:0] act,
                             input logic [DATA_WIDTH-1:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cycleCnt, act, exp);
    end
  endtask

  // Loopback: every probe beat comes back after the delay chosen for its
  // trial; junk beats are near-miss words that must never match.
  always @(posedge clk) begin
    #1;
    if (mTvalid) begin
      probeCount++;
      if (firstProbeCycle < 0) firstProbeCycle = cycleCnt;
      if (echoOn) begin
        echoQ.push_back(cycleCnt + trialDelay[(probeIdx < 8) ? probeIdx : 7]);
        probeIdx++;
      end
    end
    sTvalid = 1'b0;
    sTdata  = '0;
    if (echoQ.size() > 0 && echoQ[0] == cycleCnt) begin
      void'(echoQ.pop_front());
      sTvalid = 1'b1;
      sTdata  = PATTERN;
      lastEchoCycle = cycleCnt;
    end else if (junkOn && (cycleCnt % 3 == 0)) begin
      sTvalid = 1'b1;
      sTdata  = PATTERN ^ 256'd1;
    end
  end

  // Builds the expected timeline from the calibration rules: probe one cycle
  // after start, echo L cycles after its probe, measured latency visible the
  // cycle after the echo, verdict the cycle after that.
  task automatic buildTimeline(input int offset, input bit echo, input int rstIdx);
    int p, e, d, refL, last, sum;
    bit stop;
    for (int i = 0; i < WIN; i++) begin
      expValid[i]  = 1'b0;
      expBusy[i]   = 1'b0;
      expLocked[i] = (i == 0) ? modelLocked : 1'b0;
      expError[i]  = (i == 0) ? modelError : 1'b0;
      expDelay[i]  = modelDelay;
      expMeas[i]   = modelMeas;
    end
    p = 1;
    last = 1;
    refL = trialDelay[0];
    stop = 1'b0;
    for (int k = 0; k < TRIALS && !stop; k++) begin
      expValid[p] = 1'b1;
      if (!echo) begin
        for (int i = p; i < p + TIMEOUT_CYCLES; i++) expBusy[i] = 1'b1;
        for (int i = p + TIMEOUT_CYCLES; i < WIN; i++) expError[i] = 1'b1;
        last = p + TIMEOUT_CYCLES;
        stop = 1'b1;
      end else begin
        d = trialDelay[k];
        e = p + d;
        for (int i = p; i <= e; i++) expBusy[i] = 1'b1;
        for (int i = e + 1; i < WIN; i++) expMeas[i] = 16'(d);
        if (k > 0 && d != refL) begin
          for (int i = e + 1; i < WIN; i++) expError[i] = 1'b1;
          last = e + 1;
          stop = 1'b1;
        end else if (k == TRIALS - 1) begin
          expBusy[e + 1] = 1'b1;
          sum = refL + offset;
          if (sum >= 1 && sum <= MAX_LATENCY) begin
            for (int i = e + 2; i < WIN; i++) begin
              expLocked[i] = 1'b1;
              expDelay[i]  = 16'(sum);
            end
          end else begin
            for (int i = e + 2; i < WIN; i++) expError[i] = 1'b1;
          end
          last = e + 2;
        end else begin
          p = e + 1;
        end
      end
    end
    if (rstIdx >= 0) begin
      for (int i = rstIdx + 1; i < WIN; i++) begin
        expValid[i]  = 1'b0;
        expBusy[i]   = 1'b0;
        expLocked[i] = 1'b0;
        expError[i]  = 1'b0;
        expDelay[i]  = 16'd1;
        expMeas[i]   = 16'd0;
      end
      if (last < rstIdx + 1) last = rstIdx + 1;
    end
    tlLen       = last + 1;
    modelLocked = expLocked[last];
    modelError  = expError[last];
    modelDelay  = expDelay[last];
    modelMeas   = expMeas[last];
  endtask

  // Per-cycle comparison of every output against the expected timeline.
  always @(negedge clk) begin
    int idx;
    if (checkEn) begin
      idx = cycleCnt - baseCycle;
      if (idx >= tlLen) idx = tlLen - 1;
      if (cycleCnt > baseCycle) begin
        if (locked && lockSeen < 0) lockSeen = cycleCnt;
        if (error && errSeen < 0) errSeen = cycleCnt;
      end
      checkOutput("tvalid", mTvalid, expValid[idx]);
      checkOutput("tlast", mTlast, expValid[idx]);
      if (expValid[idx]) checkOutput("tdata", mTdata, PATTERN);
      checkOutput("busy", busy, expBusy[idx]);
      checkOutput("locked", locked, expLocked[idx]);
      checkOutput("error", error, expError[idx]);
      checkOutput("delayCount", delayCount, expDelay[idx]);
      checkOutput("measuredLatency", measuredLatency, expMeas[idx]);
    end
  end

  // One calibration run: start pulse, optional stray start / reset at given
  // cycle offsets, then enough cycles for the expected verdict to settle.
  task automatic applyStimulus(input int offset, input int d0, input int d1, input int d2,
                               input int d3, input bit echo, input bit junk,
                               input int extraStartIdx, input int rstIdx);
    @(posedge clk);
    #2;
    echoQ.delete();
    probeIdx = 0;
    probeCount = 0;
    firstProbeCycle = -1;
    lastEchoCycle = -1;
    lockSeen = -1;
    errSeen = -1;
    trialDelay[0] = d0;
    trialDelay[1] = d1;
    trialDelay[2] = d2;
    trialDelay[3] = d3;
    for (int i = 4; i < 8; i++) trialDelay[i] = d3;
    echoOn = echo;
    junkOn = junk;
    baseCycle = cycleCnt;
    buildTimeline(offset, echo, rstIdx);
    delayOffset = 16'(offset);
    start = 1'b1;
    for (int i = 1; i < tlLen + 4; i++) begin
      @(posedge clk);
      #2;
      start = (i == extraStartIdx);
      rst   = (i == rstIdx);
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) trialDelay[i] = 0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    expValid[0] = 1'b0;
    expBusy[0] = 1'b0;
    expLocked[0] = 1'b0;
    expError[0] = 1'b0;
    expDelay[0] = 16'd1;
    expMeas[0] = 16'd0;
    tlLen = 1;
    baseCycle = cycleCnt;
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("resetDelay", delayCount, 16'd1);
    checkOutput("resetMeas", measuredLatency, 16'd0);
    checkOutput("resetFlags", {mTvalid, mTlast, busy, locked, error}, 5'b00000);

    $display("[TB] no echo: timeout");
    applyStimulus(3, 0, 0, 0, 0, 1'b0, 1'b0, -1, -1);
    checkOutput("timeoutDistance", errSeen - firstProbeCycle, TIMEOUT_CYCLES);
    checkOutput("timeoutDelay", delayCount, 16'd1);
    checkOutput("timeoutError", error, 1'b1);

    $display("[TB] loop 7 offset 3");
    applyStimulus(3, 7, 7, 7, 7, 1'b1, 1'b0, -1, -1);
    checkOutput("loop7Probes", probeCount, TRIALS);
    checkOutput("loop7Meas", measuredLatency, 16'd7);
    checkOutput("loop7Delay", delayCount, 16'd10);
    checkOutput("loop7Locked", locked, 1'b1);
    checkOutput("loop7LockLatency", lockSeen - lastEchoCycle, 2);

    $display("[TB] loop 40 offset 20: sum too large");
    applyStimulus(20, 40, 40, 40, 40, 1'b1, 1'b0, -1, -1);
    checkOutput("sum60Error", error, 1'b1);
    checkOutput("sum60Delay", delayCount, 16'd10);
    checkOutput("sum60Meas", measuredLatency, 16'd40);

    $display("[TB] loop 1 offset 0: minimum legal sum");
    applyStimulus(0, 1, 1, 1, 1, 1'b1, 1'b0, -1, -1);
    checkOutput("sum1Delay", delayCount, 16'd1);
    checkOutput("sum1Locked", locked, 1'b1);

    $display("[TB] loop 30 offset 20 / 21: maximum boundary");
    applyStimulus(20, 30, 30, 30, 30, 1'b1, 1'b0, -1, -1);
    checkOutput("sum50Delay", delayCount, 16'd50);
    applyStimulus(21, 30, 30, 30, 30, 1'b1, 1'b0, -1, -1);
    checkOutput("sum51Error", error, 1'b1);
    checkOutput("sum51Delay", delayCount, 16'd50);

    $display("[TB] loop 7 offset 0xFFFF: no wrap");
    applyStimulus(16'hFFFF, 7, 7, 7, 7, 1'b1, 1'b0, -1, -1);
    checkOutput("wrapError", error, 1'b1);
    checkOutput("wrapDelay", delayCount, 16'd50);

    $display("[TB] junk beats and stray start during wait");
    applyStimulus(5, 12, 12, 12, 12, 1'b1, 1'b1, 6, -1);
    checkOutput("junkMeas", measuredLatency, 16'd12);
    checkOutput("junkDelay", delayCount, 16'd17);
    checkOutput("junkProbes", probeCount, TRIALS);

    $display("[TB] reset during wait, then recalibrate");
    applyStimulus(1, 20, 20, 20, 20, 1'b1, 1'b0, -1, 5);
    checkOutput("rstDelay", delayCount, 16'd1);
    checkOutput("rstMeas", measuredLatency, 16'd0);
    checkOutput("rstFlags", {busy, locked, error}, 3'b000);
    applyStimulus(2, 9, 9, 9, 9, 1'b1, 1'b0, -1, -1);
    checkOutput("recalDelay", delayCount, 16'd11);

`ifdef AXIS_DELAY_CAL_MULTI_EN
    $display("[TB] multi: loop 5 on all trials");
    applyStimulus(2, 5, 5, 5, 5, 1'b1, 1'b0, -1, -1);
    checkOutput("multiProbes", probeCount, 4);
    checkOutput("multiDelay", delayCount, 16'd7);
    checkOutput("multiLocked", locked, 1'b1);
    $display("[TB] multi: jitter 5/5/6");
    applyStimulus(2, 5, 5, 6, 6, 1'b1, 1'b0, -1, -1);
    checkOutput("jitterProbes", probeCount, 3);
    checkOutput("jitterError", error, 1'b1);
    checkOutput("jitterMeas", measuredLatency, 16'd6);
    checkOutput("jitterDelay", delayCount, 16'd7);
`else
    $display("[TB] echo in the last cycle before timeout");
    applyStimulus(0, TIMEOUT_CYCLES - 1, 0, 0, 0, 1'b1, 1'b0, -1, -1);
    checkOutput("lateMeas", measuredLatency, 16'(TIMEOUT_CYCLES - 1));
    checkOutput("lateError", error, 1'b1);
    checkOutput("lateDelay", delayCount, 16'd11);
`endif

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
